// File: rtl/costas_loop_sched.sv
// costas_loop_sched: acquisition/tracking scheduler for the Costas carrier loop.
// Owns the block's CtrlPort register map, measures lock quality as the sum of
// |phase error| over fixed windows and selects loop gains / NCO restarts.
module costas_loop_sched #(
  parameter int unsigned WIN_LOG2         = 8,
  parameter int unsigned LOCK_CNT_DEFAULT = 4,
  parameter int unsigned TIMEOUT_DEFAULT  = 64
) (
  input  logic        axis_data_clk,
  input  logic        axis_data_rst,
  input  logic        m_ctrlport_req_wr,
  input  logic        m_ctrlport_req_rd,
  input  logic [19:0] m_ctrlport_req_addr,
  input  logic [31:0] m_ctrlport_req_data,
  output logic        m_ctrlport_resp_ack,
  output logic [31:0] m_ctrlport_resp_data,
  input  logic [15:0] err_tdata,
  input  logic        err_tvalid,
  output logic [15:0] loop_alpha,
  output logic [15:0] loop_beta,
  output logic        nco_reset,
  output logic        locked
);

  localparam int unsigned AccW       = 16 + WIN_LOG2;
  localparam logic [15:0] TimeoutDef = 16'(TIMEOUT_DEFAULT);
  localparam logic [7:0]  LockCntDef = 8'(LOCK_CNT_DEFAULT);

  typedef enum logic [1:0] {StIdle = 2'd0, StAcq = 2'd1, StTrack = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                enable_q;
  logic [31:0]         acq_gains_q, trk_gains_q, lock_thresh_q, unlock_thresh_q;
  logic [15:0]         timeout_q;
  logic [7:0]          lock_cnt_q;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]          good_q, good_d;
  logic [15:0]         to_q, to_d;
  logic [31:0]         last_sum_q, last_sum_d;
  logic [15:0]         relock_q, relock_d;
  logic                nco_req_q, nco_req_d;

  logic [2:0]      reg_idx;
  logic            mapped, wr_en, ctrl_wr, start, stop;
  logic [31:0]     rd_data;
  logic [15:0]     abs_err;
  logic [AccW-1:0] sum;
  logic [31:0]     sum32;
  logic [7:0]      lock_eff;
  logic [8:0]      good_nx;
  logic [15:0]     to_inc;

  assign reg_idx = m_ctrlport_req_addr[4:2];
  assign mapped  = (m_ctrlport_req_addr[19:5] == 15'd0) && (m_ctrlport_req_addr[1:0] == 2'd0);
  assign wr_en   = m_ctrlport_req_wr && mapped;
  assign ctrl_wr = wr_en && (reg_idx == 3'd0);
  // Fresh ACQ entry: enable rising, or restart while remaining enabled.
  assign start   = ctrl_wr && m_ctrlport_req_data[0] && (!enable_q || m_ctrlport_req_data[1]);
  assign stop    = ctrl_wr && !m_ctrlport_req_data[0];

  // |err| saturated so -32768 contributes 32767.
  always_comb begin
    if (!err_tdata[15])             abs_err = err_tdata;
    else if (err_tdata == 16'h8000) abs_err = 16'h7FFF;
    else                            abs_err = ~err_tdata + 16'd1;
  end

  assign sum      = acc_q + AccW'(abs_err);
  assign sum32    = 32'(sum);
  assign lock_eff = (lock_cnt_q == 8'd0) ? 8'd1 : lock_cnt_q;
  assign good_nx  = (sum32 < lock_thresh_q) ? ({1'b0, good_q} + 9'd1) : 9'd0;
  assign to_inc   = (to_q == 16'hFFFF) ? to_q : to_q + 16'd1;

  // Register read mux.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      3'd0: rd_data = {31'd0, enable_q};
      3'd1: rd_data = acq_gains_q;
      3'd2: rd_data = trk_gains_q;
      3'd3: rd_data = lock_thresh_q;
      3'd4: rd_data = unlock_thresh_q;
      3'd5: rd_data = {timeout_q, 8'd0, lock_cnt_q};
      3'd6: rd_data = {relock_q, 14'd0, state_q};
      3'd7: rd_data = last_sum_q;
      default: rd_data = '0;
    endcase
  end

  // CtrlPort register writes and one-cycle response.
  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      enable_q             <= 1'b0;
      acq_gains_q          <= 32'h4000_0400;
      trk_gains_q          <= 32'h1000_0040;
      lock_thresh_q        <= 32'h0000_2000;
      unlock_thresh_q      <= 32'h0000_8000;
      timeout_q            <= TimeoutDef;
      lock_cnt_q           <= LockCntDef;
      m_ctrlport_resp_ack  <= 1'b0;
      m_ctrlport_resp_data <= 32'd0;
    end else begin
      m_ctrlport_resp_ack  <= (m_ctrlport_req_wr || m_ctrlport_req_rd) && mapped;
      m_ctrlport_resp_data <= (m_ctrlport_req_rd && mapped) ? rd_data : 32'd0;
      if (wr_en) begin
        case (reg_idx)
          3'd0: enable_q        <= m_ctrlport_req_data[0];
          3'd1: acq_gains_q     <= m_ctrlport_req_data;
          3'd2: trk_gains_q     <= m_ctrlport_req_data;
          3'd3: lock_thresh_q   <= m_ctrlport_req_data;
          3'd4: unlock_thresh_q <= m_ctrlport_req_data;
          3'd5: begin
            timeout_q  <= m_ctrlport_req_data[31:16];
            lock_cnt_q <= m_ctrlport_req_data[7:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Next state: CTRL events win over window evaluation on the same cycle.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    good_d     = good_q;
    to_d       = to_q;
    last_sum_d = last_sum_q;
    relock_d   = relock_q;
    nco_req_d  = 1'b0;
    if (stop || start) begin
      state_d   = stop ? StIdle : StAcq;
      nco_req_d = start;
      acc_d     = '0;
      cnt_d     = '0;
      good_d    = '0;
      to_d      = '0;
    end else if (state_q != StIdle && err_tvalid) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        acc_d      = '0;
        last_sum_d = sum32;
        unique case (state_q)
          StAcq: begin
            if (good_nx >= {1'b0, lock_eff}) begin
              state_d = StTrack;
              good_d  = '0;
              to_d    = '0;
            end else if (timeout_q != 16'd0 && to_inc >= timeout_q) begin
              nco_req_d = 1'b1;
              good_d    = '0;
              to_d      = '0;
            end else begin
              good_d = good_nx[7:0];
              to_d   = to_inc;
            end
          end
          StTrack: begin
            if (sum32 > unlock_thresh_q) begin
              state_d  = StAcq;
              relock_d = (relock_q == 16'hFFFF) ? relock_q : relock_q + 16'd1;
              good_d   = '0;
              to_d     = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Scheduler state register.
  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      good_q     <= '0;
      to_q       <= '0;
      last_sum_q <= '0;
      relock_q   <= '0;
      nco_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      to_q       <= to_d;
      last_sum_q <= last_sum_d;
      relock_q   <= relock_d;
      nco_req_q  <= nco_req_d;
    end
  end

  // Registered loop controls, one cycle behind state and registers.
  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      loop_alpha <= 16'd0;
      loop_beta  <= 16'd0;
      nco_reset  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      nco_reset <= nco_req_q;
      locked    <= (state_q == StTrack);
      case (state_q)
        StAcq: begin
          loop_alpha <= acq_gains_q[31:16];
          loop_beta  <= acq_gains_q[15:0];
        end
        StTrack: begin
          loop_alpha <= trk_gains_q[31:16];
          loop_beta  <= trk_gains_q[15:0];
        end
        default: begin
          loop_alpha <= 16'd0;
          loop_beta  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_costas_loop_sched.sv
// Bench for costas_loop_sched: directed and randomized CtrlPort / error-stream
// stimulus, a transaction-level reference model and a scoreboard monitor.
`timescale 1ns/1ps
module tb_costas_loop_sched;
  localparam int WinLen = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr = 1'b0, rd = 1'b0, ev = 1'b0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] err = '0;
  logic        ack, nco, lck;
  logic [31:0] rdata;
  logic [15:0] alpha, beta;

  costas_loop_sched #(.WIN_LOG2(4), .LOCK_CNT_DEFAULT(4), .TIMEOUT_DEFAULT(64)) dut (
    .axis_data_clk(clk), .axis_data_rst(rst),
    .m_ctrlport_req_wr(wr), .m_ctrlport_req_rd(rd), .m_ctrlport_req_addr(addr),
    .m_ctrlport_req_data(wdata), .m_ctrlport_resp_ack(ack), .m_ctrlport_resp_data(rdata),
    .err_tdata(err), .err_tvalid(ev), .loop_alpha(alpha), .loop_beta(beta),
    .nco_reset(nco), .locked(lck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { int due; bit chk; logic [31:0] data; } ack_t;
  typedef struct { int due; logic [15:0] a, b; logic l, n; } out_t;
  ack_t aq[$];
  out_t oq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference model: spec-level view of the scheduler.
  bit          m_en;
  int          m_state, m_wn, m_good, m_to, m_relock, m_tmo, m_lcnt;
  longint      m_wsum, m_lth, m_uth;
  logic [31:0] m_acq, m_trk, m_last;

  function automatic void model_reset();
    m_en = 0; m_state = 0; m_wn = 0; m_wsum = 0; m_good = 0; m_to = 0; m_relock = 0;
    m_last = 0; m_acq = 32'h4000_0400; m_trk = 32'h1000_0040; m_lth = 'h2000;
    m_uth = 'h8000; m_tmo = 64; m_lcnt = 4;
  endfunction

  function automatic bit is_mapped(input logic [19:0] a);
    return (a < 20'h20) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic [19:0] a);
    case (a)
      20'h00: return {31'd0, m_en};
      20'h04: return m_acq;
      20'h08: return m_trk;
      20'h0C: return 32'(m_lth);
      20'h10: return 32'(m_uth);
      20'h14: return {16'(m_tmo), 8'd0, 8'(m_lcnt)};
      20'h18: return {16'(m_relock), 14'd0, 2'(m_state)};
      default: return m_last;
    endcase
  endfunction

  function automatic void model_step(input logic w, input logic r, input logic [19:0] a,
                                     input logic [31:0] d, input logic v, input logic [15:0] e);
    bit   nco_x = 0;
    int   mag, lc;
    out_t o;
    if ((w || r) && is_mapped(a)) aq.push_back('{cyc + 1, r, r ? model_read(a) : 32'd0});
    if (w && a == 20'h00 && (!d[0] || !m_en || d[1])) begin
      // Disable, enable rising or restart: fresh window, counts cleared.
      m_wsum = 0; m_wn = 0; m_good = 0; m_to = 0;
      if (!d[0]) m_state = 0;
      else begin m_state = 1; nco_x = 1; end
    end else if (v && m_state != 0) begin
      mag = int'($signed(e));
      if (mag < 0) mag = -mag;
      if (mag > 32767) mag = 32767;
      m_wsum += mag;
      m_wn++;
      if (m_wn == WinLen) begin
        m_last = 32'(m_wsum);
        if (m_state == 1) begin
          lc = (m_lcnt == 0) ? 1 : m_lcnt;
          m_good = (m_wsum < m_lth) ? m_good + 1 : 0;
          if (m_to < 65535) m_to++;
          if (m_good >= lc) begin m_state = 2; m_good = 0; m_to = 0; end
          else if (m_tmo != 0 && m_to >= m_tmo) begin nco_x = 1; m_good = 0; m_to = 0; end
        end else if (m_wsum > m_uth) begin
          m_state = 1; m_good = 0; m_to = 0;
          if (m_relock < 65535) m_relock++;
        end
        m_wsum = 0; m_wn = 0;
      end
    end
    if (w) begin
      case (a)
        20'h00: m_en = d[0];
        20'h04: m_acq = d;
        20'h08: m_trk = d;
        20'h0C: m_lth = longint'(d);
        20'h10: m_uth = longint'(d);
        20'h14: begin m_tmo = int'(d[31:16]); m_lcnt = int'(d[7:0]); end
        default: ;
      endcase
    end
    o.due = cyc + 2;
    o.a = (m_state == 1) ? m_acq[31:16] : (m_state == 2) ? m_trk[31:16] : 16'd0;
    o.b = (m_state == 1) ? m_acq[15:0] : (m_state == 2) ? m_trk[15:0] : 16'd0;
    o.l = (m_state == 2);
    o.n = nco_x;
    oq.push_back(o);
  endfunction

  task automatic step(input logic w, input logic r, input logic [19:0] a, input logic [31:0] d,
                      input logic v, input logic [15:0] e);
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d; ev = v; err = e;
    model_step(w, r, a, d, v, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
  endtask
  task automatic rreg(input logic [19:0] a);
    step(0, 1, a, '0, 0, '0);
  endtask
  task automatic wreg(input logic [19:0] a, input logic [31:0] d);
    step(1, 0, a, d, 0, '0);
  endtask
  task automatic samples(input int n, input logic [15:0] e);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 1, e);
  endtask

  // Scoreboard monitor: acks against queued reads, outputs against model history.
  always @(posedge clk) begin
    ack_t ae;
    out_t oe;
    bit   exp_ack;
    #1;
    if (!rst) begin
      exp_ack = (aq.size() > 0) && (aq[0].due == cyc);
      if (exp_ack || ack) begin
        chk("resp_ack", 32'(ack), 32'(exp_ack));
        if (exp_ack) begin
          ae = aq.pop_front();
          if (ae.chk) chk("resp_data", rdata, ae.data);
        end
      end
      if (oq.size() > 0 && oq[0].due == cyc) begin
        oe = oq.pop_front();
        chk("loop_alpha", 32'(alpha), 32'(oe.a));
        chk("loop_beta", 32'(beta), 32'(oe.b));
        chk("locked", 32'(lck), 32'(oe.l));
        chk("nco_reset", 32'(nco), 32'(oe.n));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_data"}, rdata, 32'd0);
    chk({tag, "_alpha"}, 32'(alpha), 32'd0);
    chk({tag, "_beta"}, 32'(beta), 32'd0);
    chk({tag, "_nco"}, 32'(nco), 32'd0);
    chk({tag, "_locked"}, 32'(lck), 32'd0);
  endtask

  initial begin
    int          mode, k, mag;
    logic [19:0] a;
    logic [31:0] d;
    logic        w, r, v;
    logic [15:0] e;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Reset-state reads and unmapped access.
    rreg(20'h18);
    rreg(20'h100);
    rreg(20'h04);
    rreg(20'h14);
    idle(2);

    // Acquire on clean error, then track.
    wreg(20'h14, 32'h0040_0002);
    wreg(20'h00, 32'h1);
    rreg(20'h18);
    samples(32, 16'd0);
    idle(2);
    rreg(20'h18);

    // Unlock on a noisy window.
    samples(16, 16'd1000);
    samples(16, 16'd3000);
    idle(1);
    rreg(20'h18);
    rreg(20'h1C);

    // Saturated magnitude sum.
    samples(16, 16'h8000);
    idle(1);
    rreg(20'h1C);

    // Timeout restarts in ACQ.
    wreg(20'h14, 32'h0003_0004);
    wreg(20'h00, 32'h3);
    samples(100, 16'd4000);
    rreg(20'h18);

    // Gain write while acquiring.
    wreg(20'h04, 32'h1234_5678);
    idle(3);

    // Disable mid-window, re-enable, fresh window.
    samples(5, 16'd77);
    wreg(20'h00, 32'h0);
    idle(2);
    wreg(20'h00, 32'h1);
    for (int i = 0; i < 16; i++) step(0, 0, '0, '0, 1, 16'(i * 37));
    idle(1);
    rreg(20'h1C);

    // Randomized traffic.
    wreg(20'h14, 32'h0005_0002);
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 160 == 0) mode = $urandom_range(0, 2);
      k = $urandom_range(0, 10);
      a = (k == 10) ? 20'h100 : 20'(k * 4);
      r = ($urandom_range(0, 99) < 20);
      w = ($urandom_range(0, 99) < ((k == 0) ? 3 : 6));
      case (k)
        0: d = {30'd0, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) != 0)};
        3: d = 32'($urandom_range(0, 'h4000));
        4: d = 32'($urandom_range('h2000, 'h20000));
        5: d = {16'($urandom_range(0, 6)), 8'd0, 8'($urandom_range(0, 3))};
        default: d = $urandom();
      endcase
      v = ($urandom_range(0, 9) < 8);
      case (mode)
        0: mag = $urandom_range(0, 400);
        1: mag = $urandom_range(0, 32768);
        default: mag = $urandom_range(1500, 2500);
      endcase
      if ($urandom_range(0, 1) == 1) mag = -mag;
      e = 16'(mag);
      step(w, r, a, d, v, e);
    end
    rreg(20'h18);
    rreg(20'h1C);
    idle(3);
    repeat (3) @(negedge clk);
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);

    // Asynchronous reset mid-run discards everything.
    wreg(20'h00, 32'h1);
    samples(7, 16'd500);
    repeat (3) @(negedge clk);
    aq.delete();
    oq.delete();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rreg(20'h18);
    rreg(20'h1C);
    rreg(20'h08);
    rreg(20'h10);
    idle(3);
    repeat (3) @(negedge clk);
    chk("ack_queue_final", 32'(aq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
